// File: rtl/cool_heat_pkg.sv
// cool_heat_pkg: shared states, configuration-byte fields and mode values for cool_heat_system
package cool_heat_pkg;
    typedef enum logic [1:0] {IDLE, RAMP_UP, HOLD, RAMP_DOWN} chs_state_e;
    localparam int PWR_LSB = 0;
    localparam int PWR_MSB = 3;
    localparam int MODE_BIT = 4;
    localparam int EN_BIT = 5;
    localparam logic MODE_COOL = 1'b0;
    localparam logic MODE_HEAT = 1'b1;
endpackage

// File: rtl/cool_heat_system_if.sv
// cool_heat_system_if: configuration inputs and actuator outputs of the HVAC controller
interface cool_heat_system_if #(parameter int PWM_WIDTH = 8);
    logic [7:0] chs_conf;
    logic [PWM_WIDTH-1:0] speed;
    logic [3:0] chs_power;
    logic chs_mode;
    logic pwm_data;
    modport master (output chs_conf, speed, input chs_power, chs_mode, pwm_data);
    modport slave (input chs_conf, speed, output chs_power, chs_mode, pwm_data);
endinterface

// File: rtl/chs_pwm_gen.sv
// chs_pwm_gen: free-running fan PWM; duty is only reloaded at counter wrap so periods never tear
module chs_pwm_gen #(parameter int PWM_WIDTH = 8) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PWM_WIDTH-1:0] speed,
    input  logic                 en,
    output logic                 pwm
);
    logic [PWM_WIDTH-1:0] cnt, duty;
    // counter, duty latch at zero, registered compare gated by applied power
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            duty <= '0;
            pwm <= 1'b0;
        end else begin
            cnt <= cnt + PWM_WIDTH'(1);
            duty <= cnt == '0 ? speed : duty;
            pwm <= en && (cnt < duty);
        end
    end
endmodule

// File: rtl/cool_heat_system.sv
// cool_heat_system: power/mode ramp FSM plus fan PWM; CHS_SOFT_START_EN enables stepped ramping
module cool_heat_system import cool_heat_pkg::*; #(
    parameter int PWM_WIDTH = 8,
    parameter int RAMP_STEP_CYCLES = 4
) (
    input logic clk,
    input logic rst,
    cool_heat_system_if.slave bus
);
`ifdef CHS_SOFT_START_EN
    localparam bit SOFT = 1'b1;
`else
    localparam bit SOFT = 1'b0;
`endif
    localparam int TW = RAMP_STEP_CYCLES > 1 ? $clog2(RAMP_STEP_CYCLES) : 1;
    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_RAMP_UP = RAMP_UP;
    localparam logic [1:0] S_HOLD = HOLD;
    localparam logic [1:0] S_RAMP_DOWN = RAMP_DOWN;

    logic [1:0] state, state_n;
    logic [3:0] power, power_n, tgt, eff;
    logic mode, mode_n, req, timer_wrap, pwm, unused_rsvd;
    logic [TW-1:0] timer, timer_n;

    assign unused_rsvd = ^bus.chs_conf[7:6];
    assign tgt = bus.chs_conf[EN_BIT] ? bus.chs_conf[PWR_MSB:PWR_LSB] : 4'd0;
    assign req = bus.chs_conf[MODE_BIT] ? MODE_HEAT : MODE_COOL;
    // a pending mode change drains power to zero before the new mode may load
    assign eff = req != mode ? 4'd0 : tgt;
    assign timer_wrap = timer == TW'(RAMP_STEP_CYCLES - 1);

    // next state, power and mode; without soft start the ramp states are never entered
    always_comb begin
        state_n = state;
        power_n = power;
        mode_n = mode;
        case (state)
            S_IDLE: if (tgt != 4'd0) begin
                mode_n = req;
                power_n = SOFT ? 4'd0 : tgt;
                state_n = SOFT ? S_RAMP_UP : S_HOLD;
            end
            S_RAMP_UP:
                if (eff < power) state_n = S_RAMP_DOWN;
                else if (eff == power) state_n = power == 4'd0 ? S_IDLE : S_HOLD;
                else if (timer_wrap) begin
                    power_n = power + 4'd1;
                    state_n = power_n == eff ? S_HOLD : S_RAMP_UP;
                end
            S_HOLD: if (eff != power) begin
                power_n = SOFT ? power : eff;
                state_n = SOFT ? (eff > power ? S_RAMP_UP : S_RAMP_DOWN) : (eff == 4'd0 ? S_IDLE : S_HOLD);
            end
            default:
                if (eff > power) state_n = S_RAMP_UP;
                else if (eff == power) state_n = power == 4'd0 ? S_IDLE : S_HOLD;
                else if (timer_wrap) begin
                    power_n = power - 4'd1;
                    state_n = power_n == eff ? (eff == 4'd0 ? S_IDLE : S_HOLD) : S_RAMP_DOWN;
                end
        endcase
        timer_n = (state_n != state || state == S_IDLE || state == S_HOLD || timer_wrap) ? '0 : timer + TW'(1);
    end

    // FSM registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            power <= 4'd0;
            mode <= MODE_COOL;
            timer <= '0;
        end else begin
            state <= state_n;
            power <= power_n;
            mode <= mode_n;
            timer <= timer_n;
        end
    end

    chs_pwm_gen #(.PWM_WIDTH(PWM_WIDTH)) u_pwm (
        .clk(clk),
        .rst(rst),
        .speed(bus.speed),
        .en(power != 4'd0),
        .pwm(pwm)
    );

    assign bus.chs_power = power;
    assign bus.chs_mode = mode;
    assign bus.pwm_data = pwm;
endmodule

// File: tb/tb_cool_heat_system.sv
// tb_cool_heat_system: vector table, corner sequences and random traffic against a behavioural model
module tb_cool_heat_system;
`ifdef CHS_SOFT_START_EN
    localparam bit SOFT = 1'b1;
`else
    localparam bit SOFT = 1'b0;
`endif
    localparam int STEP = 4;

    typedef struct {
        logic [7:0] conf;
        logic [7:0] spd;
        int n;
        int pow;
        int mode;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int pass_cnt = 0;
    int tot_cnt = 0;
    int m_pow, m_mode, m_dir, m_tmr, m_cnt, m_duty, m_pwm;
    vec_t tbl[$];

    cool_heat_system_if #(.PWM_WIDTH(8)) bus ();
    cool_heat_system #(.PWM_WIDTH(8), .RAMP_STEP_CYCLES(STEP)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tot_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_clear();
        m_pow = 0; m_mode = 0; m_dir = 0; m_tmr = 0; m_cnt = 0; m_duty = 0; m_pwm = 0;
    endtask

    // One clock: the model is written as "power moves toward the effective target",
    // direction 0 meaning resting; a direction change restarts the step count.
    task automatic tick();
        int tgt, req, eff, want, n_pow, n_mode, n_dir, n_tmr;
        tgt = bus.chs_conf[5] ? int'(bus.chs_conf[3:0]) : 0;
        req = int'(bus.chs_conf[4]);
        n_pow = m_pow; n_mode = m_mode; n_dir = m_dir; n_tmr = m_tmr;
        if (m_pow == 0 && m_dir == 0) begin
            if (tgt != 0) begin
                n_mode = req;
                if (SOFT) begin n_dir = 1; n_tmr = 0; end
                else n_pow = tgt;
            end
        end else begin
            eff = (req != m_mode) ? 0 : tgt;
            if (!SOFT) n_pow = eff;
            else begin
                want = eff > m_pow ? 1 : (eff < m_pow ? -1 : 0);
                if (want != m_dir) begin
                    n_dir = want;
                    n_tmr = 0;
                end else if (m_dir != 0) begin
                    n_tmr = m_tmr + 1;
                    if (n_tmr == STEP) begin
                        n_tmr = 0;
                        n_pow = m_pow + m_dir;
                        if (n_pow == eff) n_dir = 0;
                    end
                end
            end
        end
        m_pwm = (m_pow != 0 && m_cnt < m_duty) ? 1 : 0;
        if (m_cnt == 0) m_duty = int'(bus.speed);
        m_cnt = (m_cnt + 1) % 256;
        m_pow = n_pow; m_mode = n_mode; m_dir = n_dir; m_tmr = n_tmr;
        @(posedge clk);
        #1;
        chk("cycle pwr*4+mode*2+pwm", int'(bus.chs_power) * 4 + int'(bus.chs_mode) * 2 + int'(bus.pwm_data),
            m_pow * 4 + m_mode * 2 + m_pwm);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic count_high(input int n, output int hi);
        hi = 0;
        repeat (n) begin
            tick();
            hi += int'(bus.pwm_data);
        end
    endtask

    initial begin
        int hi;
        bus.chs_conf = 8'h00;
        bus.speed = 8'h00;
        model_clear();
        if (SOFT) begin
            tbl.push_back('{8'h6B, 8'd7, 1, 0, 0});
            tbl.push_back('{8'h6B, 8'd7, 4, 1, 0});
            tbl.push_back('{8'h6B, 8'd7, 40, 11, 0});
            tbl.push_back('{8'h6F, 8'd15, 1, 11, 0});
            tbl.push_back('{8'h6F, 8'd15, 16, 15, 0});
            tbl.push_back('{8'h7F, 8'd15, 1, 15, 0});
            tbl.push_back('{8'h7F, 8'd15, 60, 0, 0});
            tbl.push_back('{8'h7F, 8'd15, 1, 0, 1});
            tbl.push_back('{8'h7F, 8'd15, 60, 15, 1});
            tbl.push_back('{8'h4F, 8'd255, 1, 15, 1});
            tbl.push_back('{8'h4F, 8'd255, 60, 0, 1});
            tbl.push_back('{8'h4F, 8'd255, 5, 0, 1});
        end else begin
            tbl.push_back('{8'h6B, 8'd7, 1, 11, 0});
            tbl.push_back('{8'h6F, 8'd15, 1, 15, 0});
            tbl.push_back('{8'h7F, 8'd15, 1, 0, 0});
            tbl.push_back('{8'h7F, 8'd15, 1, 15, 1});
            tbl.push_back('{8'h4F, 8'd255, 1, 0, 1});
            tbl.push_back('{8'h4F, 8'd255, 3, 0, 1});
            tbl.push_back('{8'h6B, 8'd0, 1, 11, 0});
        end

        do_reset();
        chk("reset chs_power", int'(bus.chs_power), 0);
        chk("reset chs_mode", int'(bus.chs_mode), 0);
        chk("reset pwm_data", int'(bus.pwm_data), 0);

        foreach (tbl[i]) begin
            bus.chs_conf = tbl[i].conf;
            bus.speed = tbl[i].spd;
            repeat (tbl[i].n) tick();
            chk($sformatf("vec%0d chs_power", i), int'(bus.chs_power), tbl[i].pow);
            chk($sformatf("vec%0d chs_mode", i), int'(bus.chs_mode), tbl[i].mode);
        end

        do_reset();
        bus.chs_conf = 8'h7B;
        bus.speed = 8'd200;
        repeat (10) tick();
        chk("pre-reset power nonzero", int'(bus.chs_power != 4'd0), 1);
        #1 rst = 1'b1;
        #1;
        chk("async reset chs_power", int'(bus.chs_power), 0);
        chk("async reset chs_mode", int'(bus.chs_mode), 0);
        chk("async reset pwm_data", int'(bus.pwm_data), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_clear();

        bus.chs_conf = 8'h6B;
        bus.speed = 8'd7;
        repeat (300) tick();
        count_high(256, hi);
        chk("pwm highs speed 7", hi, 7);
        bus.chs_conf = 8'h6F;
        for (int i = 0; i < 300 && m_cnt != 3; i++) tick();
        chk("counter align wait", m_cnt, 3);
        bus.speed = 8'd15;
        count_high(254, hi);
        chk("old duty until wrap", hi, 5);
        count_high(256, hi);
        chk("new duty after wrap", hi, 15);
        chk("power after raise", int'(bus.chs_power), 15);

        bus.chs_conf = 8'h4F;
        bus.speed = 8'd255;
        repeat (70) tick();
        chk("disabled power", int'(bus.chs_power), 0);
        count_high(256, hi);
        chk("disabled pwm speed 255", hi, 0);

        bus.chs_conf = 8'h6B;
        bus.speed = 8'd0;
        repeat (260) tick();
        chk("speed 0 power", int'(bus.chs_power), 11);
        count_high(256, hi);
        chk("pwm highs speed 0", hi, 0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(29) == 0) bus.chs_conf = 8'($urandom);
            if ($urandom_range(49) == 0) bus.speed = 8'($urandom);
            tick();
        end

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
